// File: rtl/wb_result_arbiter_pkg.sv
// Shared types, source encodings and grant helper for the write-back result arbiter.
package wb_result_arbiter_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned RD_W   = 5;

  // Source tags carried with the held entry; also the data mux select value
  localparam logic SRC_ALU  = 1'b0;
  localparam logic SRC_LOAD = 1'b1;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // One-hot (or empty) grant vector for the two requesters
  typedef struct packed {
    logic g1;
    logic g0;
  } grant_t;

  // Round-robin pick: a lone request wins outright, a tie goes to the prio index
  function automatic grant_t rr_grant(input logic v0, input logic v1, input logic prio);
    grant_t g;
    g = '0;
    if (v0 && v1) begin
      g.g1 = prio;
      g.g0 = ~prio;
    end else begin
      g.g0 = v0;
      g.g1 = v1;
    end
    return g;
  endfunction

endpackage

// File: rtl/wb_result_arbiter_if.sv
// Requester and consumer handshake bundle around the write-back arbiter.
interface wb_result_arbiter_if #(
  parameter int unsigned W  = wb_result_arbiter_pkg::DATA_W,
  parameter int unsigned RW = wb_result_arbiter_pkg::RD_W
) ();

  logic          in0_valid;
  logic [W-1:0]  in0_data;
  logic [RW-1:0] in0_rd;
  logic          in0_ready;

  logic          in1_valid;
  logic [W-1:0]  in1_data;
  logic [RW-1:0] in1_rd;
  logic          in1_ready;

  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [RW-1:0] out_rd;
  logic          out_src;
  logic          out_ready;

  // Environment side: requesters plus register-file consumer
  modport master (
    output in0_valid, in0_data, in0_rd,
    input  in0_ready,
    output in1_valid, in1_data, in1_rd,
    input  in1_ready,
    input  out_valid, out_data, out_rd, out_src,
    output out_ready
  );

  // Arbiter side
  modport slave (
    input  in0_valid, in0_data, in0_rd,
    output in0_ready,
    input  in1_valid, in1_data, in1_rd,
    output in1_ready,
    output out_valid, out_data, out_rd, out_src,
    input  out_ready
  );

endinterface

// File: rtl/wb_result_arbiter_ymuxx.sv
// W-bit 2:1 data mux; sel 0 passes a_i, sel 1 passes b_i.
module wb_result_arbiter_ymuxx #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_c
);

  // Pure combinational select
  always_comb begin
    y_c = sel_i ? b_i : a_i;
  end

endmodule

// File: rtl/wb_result_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry write-back output register.
module wb_result_arbiter
  import wb_result_arbiter_pkg::*;
#(
  parameter int unsigned W         = DATA_W,
  parameter int unsigned RW        = RD_W,
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic            clk,
  input  logic            reset,
  wb_result_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic [W-1:0]  data_q, data_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          src_q, src_d;

  grant_t        grant;
  logic          grant_any;
  logic          can_load;
  logic          load;
  logic          in0_ready_c;
  logic          in1_ready_c;
  logic [W-1:0]  mux_y;

  // Grant from live requests; a slot opens when empty or draining this cycle
  always_comb begin
    grant     = rr_grant(bus.in0_valid, bus.in1_valid, prio_q);
    grant_any = grant.g0 | grant.g1;
    can_load  = (state_q == ST_EMPTY) | bus.out_ready;
    load      = grant_any & can_load;
  end

  wb_result_arbiter_ymuxx #(
    .W (W)
  ) u_data_mux (
    .a_i   (bus.in0_data),
    .b_i   (bus.in1_data),
    .sel_i (grant.g1),
    .y_c   (mux_y)
  );

  // Occupancy state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next state: fill on any grant when empty, empty on drain without refill
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (grant_any) state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready && !grant_any) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Handshake outputs and payload/priority updates for the transfer edge
  always_comb begin
    in0_ready_c = grant.g0 & can_load;
    in1_ready_c = grant.g1 & can_load;
    data_d      = data_q;
    rd_d        = rd_q;
    src_d       = src_q;
    prio_d      = prio_q;
    if (load) begin
      data_d = mux_y;
      rd_d   = grant.g1 ? bus.in1_rd : bus.in0_rd;
      src_d  = grant.g1 ? SRC_LOAD : SRC_ALU;
      prio_d = ~grant.g1;
    end
  end

  // Held entry and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      rd_q   <= '0;
      src_q  <= SRC_ALU;
      prio_q <= 1'(PRIO_INIT);
    end else begin
      data_q <= data_d;
      rd_q   <= rd_d;
      src_q  <= src_d;
      prio_q <= prio_d;
    end
  end

  assign bus.in0_ready = in0_ready_c;
  assign bus.in1_ready = in1_ready_c;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed bench for the write-back arbiter with a cycle-level reference model.
module tb_wb_result_arbiter;

  localparam int unsigned W  = 64;
  localparam int unsigned RW = 5;
  localparam int unsigned PI = 0;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  wb_result_arbiter_if #(.W(W), .RW(RW)) bus ();

  wb_result_arbiter #(.W(W), .RW(RW), .PRIO_INIT(PI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [63:0] d0, input logic [4:0] r0,
                       input logic v1, input logic [63:0] d1, input logic [4:0] r1,
                       input logic ordy);
    bus.in0_valid = v0;
    bus.in0_data  = d0;
    bus.in0_rd    = r0;
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.in1_rd    = r1;
    bus.out_ready = ordy;
  endtask

  // Reference model: what the output slot holds and who is next in line
  logic        m_valid;
  logic [63:0] m_data;
  logic [4:0]  m_rd;
  logic        m_src;
  logic        m_prio;

  // Winner this cycle per the arbitration rules, -1 when nothing transfers
  function automatic int model_winner();
    if (m_valid && !bus.out_ready) return -1;
    if (bus.in0_valid && bus.in1_valid) return int'(m_prio);
    if (bus.in0_valid) return 0;
    if (bus.in1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_rd    <= '0;
      m_src   <= 1'b0;
      m_prio  <= 1'(PI);
    end else begin
      int w;
      w = model_winner();
      if (w == 0) begin
        m_valid <= 1'b1;
        m_data  <= bus.in0_data;
        m_rd    <= bus.in0_rd;
        m_src   <= 1'b0;
        m_prio  <= 1'b1;
      end else if (w == 1) begin
        m_valid <= 1'b1;
        m_data  <= bus.in1_data;
        m_rd    <= bus.in1_rd;
        m_src   <= 1'b1;
        m_prio  <= 1'b0;
      end else if (bus.out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    int w;
    w = model_winner();
    chk("m_in0_ready", 64'(bus.in0_ready), 64'(w == 0));
    chk("m_in1_ready", 64'(bus.in1_ready), 64'(w == 1));
    chk("m_out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("m_out_data",  bus.out_data,       m_data);
    chk("m_out_rd",    64'(bus.out_rd),    64'(m_rd));
    chk("m_out_src",   64'(bus.out_src),   64'(m_src));
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic        exp_w [4];
    logic [63:0] d;
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b1};
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset in the middle of a held entry
    drive(1, 64'hDEAD, 5'd7, 0, 0, 0, 0);
    @(posedge clk); #3;
    chk("t1_full_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_full_data", bus.out_data, 64'hDEAD);
    reset = 1'b1;
    #1;
    chk("t1_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t1_rst_data", bus.out_data, 64'h0);
    chk("t1_rst_rd", 64'(bus.out_rd), 64'd0);
    chk("t1_rst_src", 64'(bus.out_src), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 reset = 1'b0;
    drive(1, 64'h11, 5'd1, 1, 64'h22, 5'd2, 1);
    #1;
    chk("t1_rel_in0_ready", 64'(bus.in0_ready), 64'd1);
    chk("t1_rel_in1_ready", 64'(bus.in1_ready), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 1);

    // Lone requester 0
    @(posedge clk); #1;
    drive(1, 64'h5, 5'd3, 0, 0, 0, 1);
    #1;
    chk("t2_in0_ready", 64'(bus.in0_ready), 64'd1);
    chk("t2_in1_ready", 64'(bus.in1_ready), 64'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t2_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_data", bus.out_data, 64'h5);
    chk("t2_rd", 64'(bus.out_rd), 64'd3);
    chk("t2_src", 64'(bus.out_src), 64'd0);
    @(posedge clk); #1;

    // Contention from a fresh priority pointer
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 64'hA0 + 64'(k), 5'd10, 1, 64'hB0 + 64'(k), 5'd11, 1);
      #1;
      chk("t3_in0_ready", 64'(bus.in0_ready), 64'(!exp_w[k]));
      chk("t3_in1_ready", 64'(bus.in1_ready), 64'(exp_w[k]));
      @(posedge clk); #1;
      chk("t3_src", 64'(bus.out_src), 64'(exp_w[k]));
      chk("t3_data", bus.out_data, (exp_w[k] ? 64'hB0 : 64'hA0) + 64'(k));
    end

    // Backpressure with both requesting, then release
    drive(1, 64'hC0, 5'd12, 1, 64'hC1, 5'd13, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_hold_in0_ready", 64'(bus.in0_ready), 64'd0);
      chk("t4_hold_in1_ready", 64'(bus.in1_ready), 64'd0);
      @(posedge clk); #1;
      chk("t4_hold_data", bus.out_data, 64'hB3);
      chk("t4_hold_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4_rel_in0_ready", 64'(bus.in0_ready), 64'd1);
    chk("t4_rel_in1_ready", 64'(bus.in1_ready), 64'd0);
    @(posedge clk); #1;
    chk("t4_rel_data", bus.out_data, 64'hC0);
    chk("t4_rel_src", 64'(bus.out_src), 64'd0);

    // Back-to-back loads from requester 1 with rd 0
    for (int k = 0; k < 3; k++) begin
      d = 64'(k + 1);
      drive(0, 0, 0, 1, d, 5'd0, 1);
      #1;
      chk("t5_in1_ready", 64'(bus.in1_ready), 64'd1);
      @(posedge clk); #1;
      chk("t5_data", bus.out_data, d);
      chk("t5_valid", 64'(bus.out_valid), 64'd1);
      chk("t5_rd", 64'(bus.out_rd), 64'd0);
      chk("t5_src", 64'(bus.out_src), 64'd1);
    end

    // Drain with nothing requesting
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_data", bus.out_data, 64'h3);
    chk("t6_src", 64'(bus.out_src), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
